// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   state_e   : supervisor FSM states
//   PSDA_W    : width of the rPLL dynamic phase-shift select
//   max_int   : helper used to size the shared cycle counter
package pll_ctrl_pkg;

    localparam int PSDA_W = 4;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        SETTLE    = 3'd4,
        FAIL      = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, asynchronous reset to 0.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output (2-cycle latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor for the 25 MHz pixel-clock rPLL. Runs on the board
// input clock. Pulses the PLL reset, waits for lock, qualifies lock
// stability, then releases the downstream reset. Retries on lock timeout,
// gives up (sticky fail) after MAX_RETRIES attempts, and steps the rPLL
// dynamic phase select on request while running.
//   clk        : board input clock (same as rPLL CLKIN)
//   rst_n      : asynchronous active-low reset
//   lock       : rPLL LOCK, asynchronous
//   phase_up   : 1-cycle pulse, advance PSDA by one step
//   phase_down : 1-cycle pulse, retard PSDA by one step
//   pll_reset  : rPLL RESET, active-high
//   pll_psda   : rPLL PSDA
//   sys_rst_n  : downstream reset, active-low, clk domain
//   clk_stable : high in RUN only
//   fail       : sticky, retries exhausted
//   retry_cnt  : failed attempts in the current sequence
module pll_lock_supervisor
    import pll_ctrl_pkg::*;
#(
    parameter int                RESET_CYCLES        = 16,
    parameter int                LOCK_TIMEOUT_CYCLES = 270000,
    parameter int                STABLE_CYCLES       = 2700,
    parameter int                SETTLE_CYCLES       = 256,
    parameter int                MAX_RETRIES         = 3,
    parameter logic [PSDA_W-1:0] PSDA_INIT           = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lock,
    input  logic              phase_up,
    input  logic              phase_down,
    output logic              pll_reset,
    output logic [PSDA_W-1:0] pll_psda,
    output logic              sys_rst_n,
    output logic              clk_stable,
    output logic              fail,
    output logic [1:0]        retry_cnt
);

    localparam int MAX_CYC = max_int(max_int(RESET_CYCLES, LOCK_TIMEOUT_CYCLES),
                                     max_int(STABLE_CYCLES, SETTLE_CYCLES));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The lock_s=1 sample that moves WAIT_LOCK into STABLE is the first of
    // the STABLE_CYCLES consecutive samples, so STABLE itself needs one fewer.
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (lock),
        .q_o    (lock_s)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        retry_q, retry_d;
    logic [1:0]        retry_inc;
    logic [PSDA_W-1:0] psda_q, psda_d;
    logic              pll_reset_q, sys_rst_n_q, clk_stable_q, fail_q;

    assign retry_inc = retry_q + 2'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        psda_d  = psda_q;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    retry_d = 2'd0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = RESET_PLL;
                end else if (phase_up ^ phase_down) begin
                    // 4-bit arithmetic gives the mod-16 wrap in both directions.
                    psda_d  = phase_up ? (psda_q + 1'b1) : (psda_q - 1'b1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d = RESET_PLL;
                end else if (cnt_q == SET_LAST) begin
                    state_d = RUN;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        // Counter restarts on every state entry; RUN and FAIL never use it.
        if ((state_d != state_q) || (state_q == RUN) || (state_q == FAIL)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= 2'd0;
            psda_q       <= PSDA_INIT;
            pll_reset_q  <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            clk_stable_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            psda_q       <= psda_d;
            // Outputs decoded from the next state so they are glitch-free
            // flops that change on the same edge as the state.
            pll_reset_q  <= (state_d == RESET_PLL) || (state_d == FAIL);
            sys_rst_n_q  <= (state_d == RUN) || (state_d == SETTLE);
            clk_stable_q <= (state_d == RUN);
            fail_q       <= (state_d == FAIL);
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_psda   = psda_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign clk_stable = clk_stable_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

endmodule
